// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller shared by instruction fetch and load/store unit
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (global enable)
//   mem_din/mem_dout/mem_a/mem_wr   byte-wide RAM interface, read data one cycle after address
//   io_buffer_full                  stalls LSB stores to the IO window (addr[17:16]==2'b11)
//   if_req/if_addr -> if_done/if_data            word fetch port
//   lsb_req/lsb_rw/lsb_size/lsb_addr/lsb_wdata -> lsb_done/lsb_rdata   load/store port
//   roll_back_in                    misprediction flush
//   busy                            high whenever the FSM is not IDLE
// Build option: define MEM_CTRL_RR_ARB_EN for round-robin arbitration; fixed LSB priority otherwise.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        lsb_req,
    input  logic        lsb_rw,
    input  logic [1:0]  lsb_size,
    input  logic [31:0] lsb_addr,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic        roll_back_in,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d, n_q, n_d;
    logic        owner_q, owner_d;
    logic        wr_q, wr_d;
    logic [31:0] a_q, a_d, wdata_q, wdata_d, data_q, data_d;
    logic [7:0]  dout_q, dout_d;
    logic        lsb_ok, grant_lsb, accept, done_ok;
`ifdef MEM_CTRL_RR_ARB_EN
    logic        last_q, last_d;
`endif
    // stores into the IO window must wait for UART buffer space
    assign lsb_ok = lsb_req && !(lsb_rw && lsb_addr[17:16] == 2'b11 && io_buffer_full);
`ifdef MEM_CTRL_RR_ARB_EN
    // last_q = 1 means LSB was served last, so IF wins the next tie
    assign grant_lsb = lsb_ok && (!if_req || !last_q);
`else
    assign grant_lsb = lsb_ok;
`endif
    assign accept = !roll_back_in && (lsb_ok || if_req);
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_d     = n_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        a_d     = a_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        dout_d  = dout_q;
`ifdef MEM_CTRL_RR_ARB_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: if (accept) begin
                owner_d = grant_lsb;
                wr_d    = grant_lsb && lsb_rw;
                a_d     = grant_lsb ? lsb_addr : if_addr;
                n_d     = !grant_lsb ? 3'd4 : lsb_size[1] ? 3'd4 : lsb_size[0] ? 3'd2 : 3'd1;
                wdata_d = lsb_wdata;
                data_d  = '0;
                // a write issues byte 0 at the acceptance edge, so it starts one byte ahead
                dout_d  = lsb_wdata[7:0];
                cnt_d   = (grant_lsb && lsb_rw) ? 3'd1 : 3'd0;
                state_d = (grant_lsb && lsb_rw) ? WRITE : READ;
`ifdef MEM_CTRL_RR_ARB_EN
                last_d  = grant_lsb;
`endif
            end
            READ: begin
                if (roll_back_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    data_d  = '0;
                end else if (cnt_q == n_q) begin
                    state_d = DONE;
                end else begin
                    // mem_din now reflects the address driven in the previous cycle
                    data_d = data_q | ({24'b0, mem_din} << {cnt_q[1:0], 3'b000});
                    cnt_d  = cnt_q + 3'd1;
                    a_d    = (cnt_q + 3'd1 == n_q) ? a_q : a_q + 32'd1;
                end
            end
            WRITE: begin
                if (cnt_q == n_q) begin
                    state_d = DONE;
                end else begin
                    a_d    = a_q + 32'd1;
                    dout_d = 8'(wdata_q >> {cnt_q[1:0], 3'b000});
                    cnt_d  = cnt_q + 3'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            a_q     <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            dout_q  <= '0;
`ifdef MEM_CTRL_RR_ARB_EN
            last_q  <= 1'b0;
`endif
        end else if (rdy_in) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            dout_q  <= dout_d;
`ifdef MEM_CTRL_RR_ARB_EN
            last_q  <= last_d;
`endif
        end
    end
    // a flush during a read's DONE cycle cancels it; committed stores still report done
    assign done_ok   = rdy_in && state_q == DONE && !(roll_back_in && !wr_q);
    assign if_done   = done_ok && !owner_q;
    assign lsb_done  = done_ok && owner_q;
    assign if_data   = data_q;
    assign lsb_rdata = data_q;
    assign mem_a     = a_q;
    assign mem_dout  = dout_q;
    assign mem_wr    = rdy_in && state_q == WRITE;
    assign busy      = state_q != IDLE;
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk_in  input  1  system clock; all state updates on rising edge.
REQ-002 rst_in  input  1  asynchronous, active-low reset.
REQ-003 rdy_in  input  1  global enable; low freezes all state.
REQ-004 mem_din  input  8  RAM read byte, valid one cycle after its address was driven.
REQ-005 mem_dout  output  8  RAM write byte.
REQ-006 mem_a  output  32  RAM byte address.
REQ-007 mem_wr  output  1  1 = write, 0 = read.
REQ-008 io_buffer_full  input  1  UART output buffer full.
REQ-009 if_req  input  1  fetch request, level, held until if_done.
REQ-010 if_addr  input  32  fetch address, always one word.
REQ-011 if_done  output  1  one-cycle fetch completion pulse.
REQ-012 if_data  output  32  fetched word, little-endian, valid while if_done=1.
REQ-013 lsb_req  input  1  load/store request, level, held until lsb_done.
REQ-014 lsb_rw  input  1  0 = read, 1 = write.
REQ-015 lsb_size  input  2  00 byte, 01 half, 10 word; n = 1/2/4.
REQ-016 lsb_addr  input  32  first byte address.
REQ-017 lsb_wdata  input  32  store data; low n bytes are used.
REQ-018 lsb_done  output  1  one-cycle completion pulse.
REQ-019 lsb_rdata  output  32  load bytes, zero-extended, valid while lsb_done=1.
REQ-020 roll_back_in  input  1  ROB misprediction flush.
REQ-021 busy  output  1  high in any state other than IDLE.

Function
REQ-022 FSM states are IDLE, READ, WRITE and DONE; the byte counter is 3 bits.
REQ-023 IDLE: a request is accepted at the sampling edge, its address, size and data are latched, and mem_a is driven with the first address at that edge.
REQ-024 Read of n bytes: mem_a=addr+k is driven after edge k (k=0..n-1); mem_din is captured into byte k at edge k+1; the FSM enters DONE at edge n+1.
REQ-025 Write of n bytes: mem_a=addr+k, mem_dout=byte k and mem_wr=1 are driven after edge k; the FSM enters DONE at edge n with mem_wr=0.
REQ-026 DONE: exactly one cycle, with the owner's done=1, then IDLE. The requester drops req at the edge where it sees done, so no request is re-accepted.
REQ-027 Read latency: the word fetch done is visible after edge 5 counted from the acceptance edge. Write latency: byte store done is visible after edge 1.
REQ-028 Addresses increment modulo 2^32; no alignment check.
REQ-029 mem_wr=0 in IDLE, READ and DONE.
REQ-030 IO stall: an LSB write with lsb_addr[17:16]=2'b11 is not accepted while io_buffer_full=1. In that case a pending if_req is granted instead.
REQ-031 roll_back_in=1 in READ: the FSM aborts to IDLE next edge, no done is issued, and captured bytes are discarded.
REQ-032 roll_back_in=1 in DONE of a read: that cycle's done is suppressed.
REQ-033 roll_back_in=1 in WRITE: the write completes normally, because stores are committed.
REQ-034 roll_back_in=1 in IDLE: no request is accepted that edge.
REQ-035 rdy_in=0: all registers hold, and mem_wr is gated to 0 combinationally.
REQ-036 When both requests arrive together, arbitration follows REQ-040/041.

Reset
REQ-037 While rst_in=0 the outputs are: state IDLE, mem_a=0, mem_dout=0, mem_wr=0, if_done=0, lsb_done=0, if_data=0, lsb_rdata=0, busy=0.
REQ-038 While rst_in=0, the counter is 0 and last_grant=IF.
REQ-039 A reset mid-transfer abandons the transfer and issues no done.

Configuration
REQ-040 MEM_CTRL_RR_ARB_EN defined: round-robin arbitration. When both requests are pending, the grant goes to the requester not served last; last_grant updates on every acceptance.
REQ-041 MEM_CTRL_RR_ARB_EN undefined: fixed priority, LSB over IF; last_grant is absent.

Verification
REQ-042 if_req, addr 0x100, RAM bytes 13,00,00,93 -> mem_a 0x100..0x103, if_done after edge 5, if_data=0x93000013.
REQ-043 lsb_req write, size 01, addr 0x2000, wdata 0xABCD -> mem_wr=1 with (0x2000,CD) then (0x2001,AB); lsb_done after edge 2.
REQ-044 Write to 0x30000 with io_buffer_full=1 for 10 cycles -> no mem_wr. Release -> one byte written and lsb_done.
REQ-045 Word load in flight, roll_back_in pulsed after edge 2 -> IDLE next edge, no lsb_done, mem_wr stays 0.
REQ-046 if_req and lsb_req (byte read) held together from reset -> RR: LSB served first then IF, alternating thereafter. Without the macro: LSB first for every tie.
